// File: rtl/ifu_fetch_ctrl.sv
// Fetch sequencer: one imem read per instruction, pre-decodes the fetched word and
// stalls on control transfers until the resolved redirect PC arrives (no speculation).
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  output logic             io_imem_req_valid,
  input  logic             io_imem_req_ready,
  output logic [31:0]      io_imem_req_addr,
  input  logic             io_imem_resp_valid,
  input  logic [31:0]      io_imem_resp_data,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [31:0]      io_out_inst,
  output logic [31:0]      io_out_pc,
  input  logic             io_redirect_valid,
  input  logic [31:0]      io_redirect_pc,
  output logic             io_busy,
  output logic [CNT_W-1:0] io_stall_cnt,
  output logic [2:0]       io_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // a valid source holds its payload stable until that edge.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_RESP   = 3'd2,
    S_OUT    = 3'd3,
    S_WAITBR = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      pend_q, pend_d;
  logic             kill_q, kill_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [31:0]      redir_pc;
  logic             is_jump;

  assign redir_pc = io_redirect_pc & 32'hFFFF_FFFC;

  // Branch opcode 63 stalls for every f3 except 2 and 3, i.e. f3[2:1] != 2'b01.
  always_comb begin
    is_jump = 1'b0;
    case (inst_q[6:0])
      7'h6F:   is_jump = 1'b1;
      7'h67:   is_jump = (inst_q[14:12] == 3'b000);
      7'h63:   is_jump = (inst_q[14:13] != 2'b01);
      7'h73:   is_jump = (inst_q == 32'h0000_0073) || (inst_q == 32'h0010_0073) ||
                         (inst_q == 32'h3020_0073);
      default: is_jump = 1'b0;
    endcase
  end

  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    inst_d            = inst_q;
    pend_d            = pend_q;
    kill_d            = kill_q;
    stall_cnt_d       = stall_cnt_q;
    io_imem_req_valid = 1'b0;
    io_out_valid      = 1'b0;
    io_busy           = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (io_redirect_valid) pc_d = redir_pc;
      end
      S_REQ: begin
        io_imem_req_valid = 1'b1;
        if (io_imem_req_ready) begin
          state_d = S_RESP;
          // The stale request is already out; remember where to go once its data returns.
          if (io_redirect_valid) begin
            kill_d = 1'b1;
            pend_d = redir_pc;
          end
        end else if (io_redirect_valid) begin
          pc_d = redir_pc;
        end
      end
      S_RESP: begin
        if (io_redirect_valid) begin
          if (io_imem_resp_valid) begin
            pc_d    = redir_pc;
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d = 1'b1;
            pend_d = redir_pc;
          end
        end else if (io_imem_resp_valid) begin
          if (kill_q) begin
            pc_d    = pend_q;
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d  = io_imem_resp_data;
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        io_out_valid = !io_redirect_valid;
        if (io_redirect_valid) begin
          pc_d    = redir_pc;
          state_d = S_REQ;
        end else if (io_out_ready) begin
          if (is_jump) begin
            state_d = S_WAITBR;
          end else begin
            pc_d    = pc_q + 32'd4;
            state_d = S_REQ;
          end
        end
      end
      S_WAITBR: begin
        io_busy = 1'b1;
        if (stall_cnt_q != {CNT_W{1'b1}})
          stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (io_redirect_valid) begin
          pc_d    = redir_pc;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      inst_q      <= 32'd0;
      pend_q      <= 32'd0;
      kill_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      pend_q      <= pend_d;
      kill_q      <= kill_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign io_imem_req_addr = pc_q;
  assign io_out_pc        = pc_q;
  assign io_out_inst      = inst_q;
  assign io_stall_cnt     = stall_cnt_q;
  assign io_dbg_state     = state_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Randomized bench for ifu_fetch_ctrl: random memory latency, IDU back-pressure and
// redirects, checked against a program-order reference of which (pc, inst) must be delivered.
module tb_ifu_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          CNT_W    = 4;
  localparam int          N_CYCLES = 3000;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid, req_ready;
  logic [31:0]      req_addr;
  logic             resp_valid;
  logic [31:0]      resp_data;
  logic             out_valid, out_ready;
  logic [31:0]      out_inst, out_pc;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [2:0]       dbg_state;

  ifu_fetch_ctrl #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .io_imem_req_valid(req_valid), .io_imem_req_ready(req_ready), .io_imem_req_addr(req_addr),
    .io_imem_resp_valid(resp_valid), .io_imem_resp_data(resp_data),
    .io_out_valid(out_valid), .io_out_ready(out_ready),
    .io_out_inst(out_inst), .io_out_pc(out_pc),
    .io_redirect_valid(redirect_valid), .io_redirect_pc(redirect_pc),
    .io_busy(busy), .io_stall_cnt(stall_cnt), .io_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          hs_count = 0;
  bit          run_en = 1'b0;
  bit          waiting_m = 1'b0;
  int          cnt_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: a deterministic mix of plain ops and control transfers.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    logic [2:0]  f3;
    h = (a ^ 32'h5BD1_E995) * 32'h9E37_79B1;
    h = h ^ (h >> 15);
    f3 = (h[14:12] == 3'd0) ? 3'd1 : h[14:12];
    case (h[3:0])
      4'd6:       return {h[31:12], 5'd1, 7'h6F};
      4'd7:       return {h[31:20], 5'd1, 3'b000, 5'd1, 7'h67};
      4'd8, 4'd9: return {h[31:25], 5'd2, 5'd1, h[18:16], h[11:7], 7'h63};
      4'd10:      return {h[31:20], 5'd1, f3, 5'd1, 7'h67};
      4'd11: begin
        case (h[21:20])
          2'd0:    return 32'h0000_0073;
          2'd1:    return 32'h0010_0073;
          2'd2:    return 32'h3020_0073;
          default: return 32'h0020_0073;
        endcase
      end
      4'd12:      return 32'h1050_0073;
      default:    return {h[31:20], 5'd0, 3'b000, 5'd1, 7'h13};
    endcase
  endfunction

  // Reference rule: which fetched words must stall fetch until a redirect.
  function automatic bit ref_is_jump(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    op = w[6:0];
    f3 = w[14:12];
    if (w == 32'h0000_0073 || w == 32'h0010_0073 || w == 32'h3020_0073) return 1'b1;
    if (op == 7'h6F) return 1'b1;
    if (op == 7'h67) return f3 == 3'd0;
    if (op == 7'h63) return !(f3 == 3'd2 || f3 == 3'd3);
    return 1'b0;
  endfunction

  // ---------------- driver: memory, IDU, redirects ----------------
  int          resp_wait = -1;
  logic [31:0] resp_addr = '0;

  initial begin
    forever begin
      @(negedge clock);
      if (run_en) begin
        resp_valid = 1'b0;
        resp_data  = $urandom;
        if (resp_wait >= 0) begin
          if (resp_wait == 0) begin
            resp_valid = 1'b1;
            resp_data  = mem_word(resp_addr);
          end
          resp_wait--;
        end
        req_ready = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        redirect_valid = busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0);
        if (redirect_valid) begin
          if ($urandom_range(0, 15) == 0) redirect_pc = 32'hFFFF_FFF8;
          else redirect_pc = RESET_PC + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
          // Whatever was in flight is dropped: the next delivery must come from the target.
          exp_q.delete();
          exp_q.push_back(redirect_pc & 32'hFFFF_FFFC);
        end
        #1;
        if (req_valid && req_ready) begin
          resp_addr = req_addr;
          resp_wait = $urandom_range(0, 2);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  bit          prev_req_hold = 1'b0, prev_redirect = 1'b0, prev_out_hold = 1'b0;
  logic [31:0] hold_addr = '0, hold_pc = '0, hold_inst = '0;
  int          idle_cycles = 0;

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clock);
      #2;
      if (run_en) begin
        check("busy", {31'd0, busy}, {31'd0, waiting_m});
        check("stall_cnt", {28'd0, stall_cnt}, cnt_m);
        if (waiting_m) check("no_req_while_stalled", {31'd0, req_valid}, 32'd0);
        if (prev_req_hold && !prev_redirect) check("req_addr_stable", req_addr, hold_addr);
        if (prev_out_hold) begin
          check("out_pc_stable", out_pc, hold_pc);
          check("out_inst_stable", out_inst, hold_inst);
        end
        prev_req_hold = req_valid && !req_ready;
        prev_redirect = redirect_valid;
        hold_addr     = req_addr;
        prev_out_hold = out_valid && !out_ready;
        hold_pc       = out_pc;
        hold_inst     = out_inst;

        if (waiting_m && cnt_m < 15) cnt_m++;
        idle_cycles++;
        if (redirect_valid) begin
          waiting_m = 1'b0;
          check("out_valid_gated_by_redirect", {31'd0, out_valid}, 32'd0);
        end else if (out_valid && out_ready) begin
          idle_cycles = 0;
          hs_count++;
          if (exp_q.size() == 0) begin
            check("unexpected_delivery_pc", out_pc, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("out_pc", out_pc, e);
            check("out_inst", out_inst, mem_word(e));
            if (ref_is_jump(mem_word(e))) waiting_m = 1'b1;
            else exp_q.push_back(e + 32'd4);
          end
        end
        if (idle_cycles > 100) begin
          check("progress_timeout", idle_cycles, 0);
          idle_cycles = 0;
        end
      end
    end
  end

  // ---------------- sequence / final report ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, {31'd0, req_valid}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_stall_cnt"}, {28'd0, stall_cnt}, 32'd0);
    check({tag, "_req_addr"}, req_addr, RESET_PC);
    check({tag, "_out_pc"}, out_pc, RESET_PC);
    check({tag, "_out_inst"}, out_inst, 32'd0);
    check({tag, "_state_idle"}, {29'd0, dbg_state}, 32'd0);
  endtask

  task automatic drive_idle();
    req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
    out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
  endtask

  initial begin
    drive_idle();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    #1 check("no_req_on_reset_release", {31'd0, req_valid}, 32'd0);
    @(posedge clock);
    #1;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    run_en = 1'b1;

    repeat (N_CYCLES) @(posedge clock);
    #1 run_en = 1'b0;
    check("deliveries_made", {31'd0, hs_count >= 100}, 32'd1);

    drive_idle();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_reset_outputs("midrun_reset");
    reset = 1'b0;
    #1 check("no_req_after_midrun_reset", {31'd0, req_valid}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    check("req_after_idle", {31'd0, req_valid}, 32'd1);
    check("req_addr_after_idle", req_addr, RESET_PC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
